// File: rtl/vdp_io_pkg.sv
// Shared constants and state encoding for the VDP I/O port block.
package vdp_io_pkg;

  localparam logic [1:0] PORT_VRAM = 2'd0;
  localparam logic [1:0] PORT_CTRL = 2'd1;
  localparam logic [1:0] PORT_PAL  = 2'd2;
  localparam logic [1:0] PORT_IND  = 2'd3;

  localparam logic [5:0] R14 = 6'd14;
  localparam logic [5:0] R15 = 6'd15;
  localparam logic [5:0] R16 = 6'd16;
  localparam logic [5:0] R17 = 6'd17;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_VRAM_REQ,
    ST_VRAM_WAIT
  } state_t;

endpackage

// File: rtl/vdp_io_port_if.sv
// Internal bus from msx_slot: valid/ready request handshake plus read-data strobe.
interface vdp_io_port_if;
  logic        memreq;
  logic        ioreq;
  logic [15:0] address;
  logic        write;
  logic        valid;
  logic        ready;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        rdata_en;

  modport master (
    output memreq, ioreq, address, write, valid, wdata,
    input  ready, rdata, rdata_en
  );

  modport slave (
    input  memreq, ioreq, address, write, valid, wdata,
    output ready, rdata, rdata_en
  );
endinterface

// File: rtl/vdp_io_vram_if.sv
// VRAM side of the I/O port: address counter, read-ahead latch and request handshake.
module vdp_io_vram_if
  import vdp_io_pkg::*;
#(
  parameter int unsigned VRAM_AW = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               start_write,
  input  logic [7:0]         wdata,
  input  logic               load,
  input  logic [VRAM_AW-1:0] load_addr,
  output logic               busy,
  output logic [7:0]         latch,
  output logic               vram_valid,
  input  logic               vram_ready,
  output logic               vram_write,
  output logic [VRAM_AW-1:0] vram_address,
  output logic [7:0]         vram_wdata,
  input  logic [7:0]         vram_rdata,
  input  logic               vram_rdata_en
);

  state_t             state, state_n;
  logic [VRAM_AW-1:0] counter;

  assign vram_valid   = (state == ST_VRAM_REQ);
  assign busy         = (state != ST_IDLE);
  assign vram_address = counter;

  // Next-state: request until accepted, reads then wait for the data strobe.
  always_comb begin
    state_n = state;
    case (state)
      ST_IDLE:      if (start) state_n = ST_VRAM_REQ;
      ST_VRAM_REQ:  if (vram_ready) state_n = vram_write ? ST_IDLE : ST_VRAM_WAIT;
      ST_VRAM_WAIT: if (vram_rdata_en) state_n = ST_IDLE;
      default:      state_n = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // Counter load/increment, request capture and read-ahead latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      counter    <= '0;
      latch      <= '0;
      vram_write <= 1'b0;
      vram_wdata <= '0;
    end else begin
      if (load)                                 counter <= load_addr;
      else if (state == ST_VRAM_REQ && vram_ready) counter <= counter + 1'b1;
      if (start && state == ST_IDLE) begin
        vram_write <= start_write;
        vram_wdata <= wdata;
      end
      if (state == ST_VRAM_WAIT && vram_rdata_en) latch <= vram_rdata;
    end
  end

endmodule

// File: rtl/vdp_io_port.sv
// V9938 I/O ports 98h-9Bh: VRAM data, control, palette and indirect register ports.
module vdp_io_port
  import vdp_io_pkg::*;
#(
  parameter logic [7:0]  IO_BASE = 8'h98,
  parameter int unsigned VRAM_AW = 17
) (
  input  logic               clk42m,
  input  logic               reset,
  vdp_io_port_if.slave       bus,
  output logic               reg_write,
  output logic [5:0]         reg_num,
  output logic [7:0]         reg_data,
  output logic               palette_write,
  output logic [3:0]         palette_num,
  output logic [8:0]         palette_rgb,
  output logic               vram_valid,
  input  logic               vram_ready,
  output logic               vram_write,
  output logic [VRAM_AW-1:0] vram_address,
  output logic [7:0]         vram_wdata,
  input  logic [7:0]         vram_rdata,
  input  logic               vram_rdata_en,
  output logic [3:0]         status_select,
  input  logic [7:0]         status_data,
  output logic               status_read
);

  logic       armed, ctrl_flag, pal_flag, r17_hold;
  logic [7:0] ctrl_byte;
  logic [5:0] pal_rb, r17_num;
  logic [2:0] r14;
  logic [3:0] r15, r16;
  logic       rd_pend, rd_stat;
  logic [7:0] rd_val;

  logic               hit, accept, busy;
  logic [7:0]         latch;
  logic               start, start_write, load;
  logic [VRAM_AW-1:0] load_addr;
  logic               rw_en, pal_en;
  logic [5:0]         rw_num;
  logic [7:0]         rw_data;
  logic               ctrl_flag_n, pal_flag_n, rd_n, rd_stat_n;
  logic [7:0]         ctrl_byte_n, rd_val_n;
  logic [5:0]         pal_rb_n, r17_num_n;
  logic               unused_addr;

  assign unused_addr   = ^bus.address[15:8];
  assign status_select = r15;
  assign hit    = bus.valid & bus.ioreq & ~bus.memreq & (bus.address[7:2] == IO_BASE[7:2]);
  assign accept = hit & armed & ~busy;
  assign load_addr = VRAM_AW'({r14, bus.wdata[5:0], ctrl_byte});

  vdp_io_vram_if #(.VRAM_AW(VRAM_AW)) u_vram (
    .clk           (clk42m),
    .rst           (reset),
    .start         (start),
    .start_write   (start_write),
    .wdata         (bus.wdata),
    .load          (load),
    .load_addr     (load_addr),
    .busy          (busy),
    .latch         (latch),
    .vram_valid    (vram_valid),
    .vram_ready    (vram_ready),
    .vram_write    (vram_write),
    .vram_address  (vram_address),
    .vram_wdata    (vram_wdata),
    .vram_rdata    (vram_rdata),
    .vram_rdata_en (vram_rdata_en)
  );

  // Port decode: work out the action of an accepted access.
  always_comb begin
    start       = 1'b0;
    start_write = 1'b0;
    load        = 1'b0;
    rw_en       = 1'b0;
    rw_num      = '0;
    rw_data     = '0;
    pal_en      = 1'b0;
    ctrl_flag_n = ctrl_flag;
    ctrl_byte_n = ctrl_byte;
    pal_flag_n  = pal_flag;
    pal_rb_n    = pal_rb;
    r17_num_n   = r17_num;
    rd_n        = 1'b0;
    rd_stat_n   = 1'b0;
    rd_val_n    = 8'hFF;
    if (accept) begin
      case (bus.address[1:0])
        PORT_VRAM: begin
          ctrl_flag_n = 1'b0;
          start       = 1'b1;
          start_write = bus.write;
          rd_n        = ~bus.write;
          rd_val_n    = latch;
        end
        PORT_CTRL: begin
          if (!bus.write) begin
            ctrl_flag_n = 1'b0;
            rd_n        = 1'b1;
            rd_stat_n   = 1'b1;
          end else if (!ctrl_flag) begin
            ctrl_byte_n = bus.wdata;
            ctrl_flag_n = 1'b1;
          end else begin
            ctrl_flag_n = 1'b0;
            if (bus.wdata[7]) begin
              rw_en   = 1'b1;
              rw_num  = bus.wdata[5:0];
              rw_data = ctrl_byte;
            end else begin
              load  = 1'b1;
              start = ~bus.wdata[6];
            end
          end
        end
        PORT_PAL: begin
          if (!bus.write) begin
            rd_n = 1'b1;
          end else if (!pal_flag) begin
            pal_rb_n   = {bus.wdata[6:4], bus.wdata[2:0]};
            pal_flag_n = 1'b1;
          end else begin
            pal_flag_n = 1'b0;
            pal_en     = 1'b1;
          end
        end
        default: begin
          if (!bus.write) begin
            rd_n = 1'b1;
          end else begin
            rw_en   = (r17_num != R17);
            rw_num  = r17_num;
            rw_data = bus.wdata;
            if (!r17_hold) r17_num_n = r17_num + 6'd1;
          end
        end
      endcase
    end
  end

  // Bus handshake, read-data return and port sequence flags.
  always_ff @(posedge clk42m or posedge reset) begin
    if (reset) begin
      armed        <= 1'b0;
      bus.ready    <= 1'b0;
      bus.rdata    <= '0;
      bus.rdata_en <= 1'b0;
      status_read  <= 1'b0;
      rd_pend      <= 1'b0;
      rd_stat      <= 1'b0;
      rd_val       <= '0;
      ctrl_flag    <= 1'b0;
      ctrl_byte    <= '0;
      pal_rb       <= '0;
    end else begin
      if (accept)          armed <= 1'b0;
      else if (!bus.valid) armed <= 1'b1;
      bus.ready    <= accept;
      rd_pend      <= rd_n;
      rd_stat      <= rd_stat_n;
      rd_val       <= rd_val_n;
      bus.rdata_en <= rd_pend;
      status_read  <= rd_pend & rd_stat;
      if (rd_pend) bus.rdata <= rd_stat ? status_data : rd_val;
      ctrl_flag    <= ctrl_flag_n;
      ctrl_byte    <= ctrl_byte_n;
      pal_rb       <= pal_rb_n;
    end
  end

  // Register/palette write pulses and the R#14-R#17 shadows.
  always_ff @(posedge clk42m or posedge reset) begin
    if (reset) begin
      reg_write     <= 1'b0;
      reg_num       <= '0;
      reg_data      <= '0;
      palette_write <= 1'b0;
      palette_num   <= '0;
      palette_rgb   <= '0;
      pal_flag      <= 1'b0;
      r14           <= '0;
      r15           <= '0;
      r16           <= '0;
      r17_num       <= '0;
      r17_hold      <= 1'b0;
    end else begin
      reg_write     <= rw_en;
      palette_write <= pal_en;
      if (rw_en) begin
        reg_num  <= rw_num;
        reg_data <= rw_data;
      end
      if (pal_en) begin
        palette_num <= r16;
        palette_rgb <= {pal_rb[5:3], bus.wdata[2:0], pal_rb[2:0]};
        r16         <= r16 + 4'd1;
      end
      pal_flag <= pal_flag_n;
      r17_num  <= r17_num_n;
      // Shadow updates come last so a register write wins over sequencing.
      if (rw_en) begin
        case (rw_num)
          R14: r14 <= rw_data[2:0];
          R15: r15 <= rw_data[3:0];
          R16: begin
            r16      <= rw_data[3:0];
            pal_flag <= 1'b0;
          end
          R17: begin
            r17_num  <= rw_data[5:0];
            r17_hold <= rw_data[7];
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/vdp_io_port.md
Name: vdp_io_port

Overview:
- Downstream consumer of the msx_slot internal bus (bus_valid/bus_ready/bus_rdata_en handshake).
- Decodes VDP I/O ports 98h-9Bh and implements the V9938 port protocols:
  - VRAM data port with read-ahead latch and auto-increment
  - two-byte control sequence
  - palette sequence
  - indirect register port
- Drives register-write, palette-write and VRAM request interfaces into the VDP core.

Parameters:
- IO_BASE, 8'h98: base I/O address; bus_address[7:2] must equal IO_BASE[7:2]; bus_address[1:0] selects the port.
- VRAM_AW, 17: VRAM address width; the address counter wraps modulo 2^VRAM_AW.

Ports:
- clk42m  in  1  system clock, 42.95454MHz
- reset  in  1  asynchronous, active-high reset
- bus_memreq  in  1  memory request (ignored by this block)
- bus_ioreq  in  1  I/O request
- bus_address  in  16  bus address; only bits [7:0] are decoded
- bus_write  in  1  1=write, 0=read
- bus_valid  in  1  request valid; held until bus_ready
- bus_ready  out  1  one-cycle accept pulse
- bus_wdata  in  8  write data
- bus_rdata  out  8  read data
- bus_rdata_en  out  1  one-cycle read-data strobe
- reg_write  out  1  one-cycle register write pulse
- reg_num  out  6  register number
- reg_data  out  8  register data
- palette_write  out  1  one-cycle palette write pulse
- palette_num  out  4  palette entry
- palette_rgb  out  9  {R[2:0],G[2:0],B[2:0]}
- vram_valid  out  1  VRAM request; held until vram_ready
- vram_ready  in  1  VRAM request accepted
- vram_write  out  1  1=write, 0=read
- vram_address  out  VRAM_AW  VRAM address
- vram_wdata  out  8  VRAM write data
- vram_rdata  in  8  VRAM read data
- vram_rdata_en  in  1  VRAM read-data strobe
- status_select  out  4  R#15[3:0]
- status_data  in  8  selected status register value
- status_read  out  1  one-cycle pulse on a port-99h read; the core clears flags on it

Behaviour:
- Reset values:
  - all outputs 0
  - internal state: address counter 0, read-ahead latch 00h, first-byte flags 0, R#14/R#15/R#16/R#17 shadows 0, state ST_IDLE
- Hit condition: bus_valid & bus_ioreq & ~bus_memreq & address match. On a miss, bus_ready is never driven.
- States:
  - ST_IDLE: on a hit, pulse bus_ready the next cycle and perform the port action. Reads pulse bus_rdata_en 1 cycle after bus_ready. The next hit is accepted only after bus_valid has been low for at least 1 cycle.
  - ST_VRAM_REQ: vram_valid=1 until vram_ready.
  - ST_VRAM_WAIT: wait for vram_rdata_en, load the latch, return to ST_IDLE.
  - No bus hit is accepted outside ST_IDLE.
- 98h write:
  - vram_write=1, vram_address=counter, vram_wdata=bus_wdata → ST_VRAM_REQ.
  - Counter +1 on vram_ready.
  - Clears the 99h first-byte flag.
- 98h read:
  - bus_rdata=latch; then prefetch read at counter → ST_VRAM_REQ/ST_VRAM_WAIT.
  - Counter +1 on vram_ready.
  - Clears the 99h flag.
- 99h write, flag=0: latch byte; flag=1.
- 99h write, flag=1: flag=0, then by second byte b:
  - b[7]=1: reg_write pulse, reg_num=b[5:0], reg_data=latched byte.
  - b[7]=0: counter={R#14[2:0], b[5:0], latched}; if b[6]=0, issue a prefetch read (as 98h read, without bus_rdata_en), counter +1.
- 99h read:
  - bus_rdata=status_data, status_read pulse coincident with bus_rdata_en.
  - Clears the 99h flag.
- 9Ah write:
  - First byte: latch R=b[6:4], B=b[2:0].
  - Second byte: palette_write pulse, palette_num=R#16[3:0], G=b[2:0]; R#16 +1 mod 16.
  - Sequence flag is separate from the 99h flag.
- 9Bh write:
  - reg_write to R#17[5:0] with bus_wdata; a target of 17 is suppressed (no pulse).
  - If R#17[7]=0, R#17[5:0] +1 mod 64.
- Reads of 9Ah/9Bh return FFh.
- Every reg_write updates the R#14/R#15/R#16/R#17 shadows.
- Writing R#16 clears the 9Ah flag.
- Counter wraps 1FFFFh → 00000h.
- reset mid-transaction: vram_valid and all pulses drop immediately; a pending bus request gets no bus_ready.

Decomposition:
- Package vdp_io_pkg:
  - port offset constants PORT_VRAM=2'd0, PORT_CTRL=2'd1, PORT_PAL=2'd2, PORT_IND=2'd3
  - state enum
  - register index constants R14/R15/R16/R17
- Sub-module vdp_io_vram_if: owns the address counter, read-ahead latch and the ST_VRAM_REQ/ST_VRAM_WAIT handshake.

Test Plan:
- Write 99h 05h then 87h → reg_write, reg_num=07h, reg_data=05h, one cycle; bus_ready once per byte.
- Write R#14=01h; 99h 00h, 40h; 98h AAh → vram_address=04000h, wdata=AAh, held until vram_ready; second 98h write → 04001h.
- 99h 34h, 12h (read setup) → prefetch at 01234h; supply vram_rdata=5Ah; 98h read → bus_rdata=5Ah, next prefetch at 01235h.
- R#16=3; 9Ah 72h, 05h → palette_num=3, palette_rgb={3'd7,3'd5,3'd2}; R#16 shadow=4.
- R#17=3Eh; 9Bh 11h, 22h, 33h → reg_write R#62=11h, R#63=22h, R#0=33h. With R#17=91h, a 9Bh write produces no pulse.
- vram_ready held low with reset asserted → vram_valid=0 and the counter returns to 0 immediately; memreq or address 88h → no bus_ready.
